// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory.
// Define MEM_ARB_FAIRNESS_EN to add a starvation counter that lets fetch win after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:2] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_din,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_en,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t state_q, state_d;
    logic   rd_pend_q, rd_pend_d;
    logic   rd_owner_q, rd_owner_d;   // 1: pending read belongs to data port
    logic   win_i, win_d;
    logic   fetch_first;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign fetch_first = if_req && (starve_q == LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt)
            starve_d = '0;
        else if (d_gnt && (starve_q != LIMIT))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
    end
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        win_i = 1'b0;
        win_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                win_d = d_req && !fetch_first;
                win_i = if_req && !win_d;
            end
            HOLD_I:  win_i = 1'b1;
            HOLD_D:  win_d = 1'b1;
            default: ;
        endcase
        // Requests seen while reset is held must not reach the memory.
        if (!rst) begin
            win_i = 1'b0;
            win_d = 1'b0;
        end

        mem_en   = win_i || win_d;
        mem_we   = win_d && d_we;
        mem_addr = win_d ? d_addr : (win_i ? if_addr : '0);
        mem_din  = win_d ? d_din : '0;
        if_gnt   = win_i && mem_ready;
        d_gnt    = win_d && mem_ready;

        if (mem_en && !mem_ready)
            state_d = win_d ? HOLD_D : HOLD_I;
        else
            state_d = IDLE;

        rd_pend_d  = if_gnt || (d_gnt && !d_we);
        rd_owner_d = d_gnt;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign if_rvalid = rd_pend_q && !rd_owner_q;
    assign d_rvalid  = rd_pend_q && rd_owner_q;
    assign if_rdata  = mem_dout;
    assign d_rdata   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:2] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:2] d_addr = '0;
    logic [31:0] d_din = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:2] mem_addr;
    logic [31:0] mem_din;
    logic        mem_en, mem_we;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_dout = '0;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // flag order: {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] EN   = 6'b000010;
    localparam logic [5:0] IG   = 6'b100010;
    localparam logic [5:0] DGR  = 6'b010010;
    localparam logic [5:0] DGW  = 6'b010011;
    localparam logic [5:0] IRV  = 6'b001000;
    localparam logic [5:0] DRV  = 6'b000100;

    typedef struct packed {
        logic [15:0] tag;
        logic [5:0]  flags;
        logic [29:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic ir, input logic [29:0] ia,
                        input logic dr, input logic dw, input logic [29:0] da,
                        input logic [31:0] dd, input logic rdy,
                        input logic [5:0] e_flags, input logic [29:0] e_addr,
                        input logic [31:0] e_din);
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        rst       = r;
        if_req    = ir;
        if_addr   = ia;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_din     = dd;
        mem_ready = rdy;
        mem_dout  = 32'hC0DE_0000 | 32'(step_no);
        e.tag   = 16'(step_no);
        e.flags = e_flags;
        e.addr  = e_addr;
        e.din   = e_din;
        e.rdata = 32'hC0DE_0000 | 32'(step_no);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] e_flags);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, e_flags, '0, '0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [67:0] act;
        forever begin
            @(negedge clk);
            act = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_din};
            if (exp_q.size() == 0) begin
                if (act != '0) check("unexpected_activity", 128'(act), '0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("step%0d_ctl", e.tag), 128'(act), 128'({e.flags, e.addr, e.din}));
                check($sformatf("step%0d_rdata", e.tag), 128'({if_rdata, d_rdata}),
                      128'({e.rdata, e.rdata}));
            end
        end
    end

    initial begin : stimulus
        logic       prev_i;
        logic       is_i;
        logic [5:0] f;

        // Reset held with both requesters active: everything stays quiet.
        step(1'b0, 1'b1, 30'h10, 1'b1, 1'b1, 30'h20, 32'h55, 1'b1, NONE, '0, '0);
        #2 check("reset_outputs", 128'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_din}), '0);
        step(1'b0, 1'b1, 30'h10, 1'b1, 1'b1, 30'h20, 32'h55, 1'b1, NONE, '0, '0);

        // Lone fetch read, granted the first cycle out of reset.
        step(1'b1, 1'b1, 30'h10, 1'b0, 1'b0, '0, '0, 1'b1, IG, 30'h10, '0);
        idle(IRV);

        // Fetch and data write together: data first, write gives no rvalid.
        step(1'b1, 1'b1, 30'h30, 1'b1, 1'b1, 30'h20, 32'hDEADBEEF, 1'b1, DGW, 30'h20, 32'hDEADBEEF);
        step(1'b1, 1'b1, 30'h30, 1'b0, 1'b0, '0, '0, 1'b1, IG, 30'h30, '0);
        idle(IRV);

        // Data read stalled three cycles; fetch arriving meanwhile must not steal the bus.
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 30'h40, '0, 1'b0, EN, 30'h40, '0);
        step(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h40, '0, 1'b0, EN, 30'h40, '0);
        step(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h40, '0, 1'b0, EN, 30'h40, '0);
        step(1'b1, 1'b1, 30'h50, 1'b1, 1'b0, 30'h40, '0, 1'b1, DGR, 30'h40, '0);
        step(1'b1, 1'b1, 30'h50, 1'b0, 1'b0, '0, '0, 1'b1, IG | DRV, 30'h50, '0);
        idle(IRV);

        // Both held high: D,D,D,I with fairness, D forever without.
        prev_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
            is_i = (k % 4 == 3);
`else
            is_i = 1'b0;
`endif
            f = is_i ? IG : DGR;
            if (k > 0) f = f | (prev_i ? IRV : DRV);
            step(1'b1, 1'b1, 30'h70, 1'b1, 1'b0, 30'h60, '0, 1'b1, f, is_i ? 30'h70 : 30'h60, '0);
            prev_i = is_i;
        end
        idle(prev_i ? IRV : DRV);

        // Alternating owners at full throughput.
        for (int k = 0; k < 6; k++) begin
            is_i = (k % 2 == 0);
            f = is_i ? IG : DGR;
            if (k > 0) f = f | (is_i ? DRV : IRV);
            if (is_i)
                step(1'b1, 1'b1, 30'h80 + 30'(k), 1'b0, 1'b0, '0, '0, 1'b1, f, 30'h80 + 30'(k), '0);
            else
                step(1'b1, 1'b0, '0, 1'b1, 1'b0, 30'h90 + 30'(k), '0, 1'b1, f, 30'h90 + 30'(k), '0);
        end
        idle(DRV);

        // Reset right after an accepted read discards its rvalid.
        step(1'b1, 1'b1, 30'hA0, 1'b0, 1'b0, '0, '0, 1'b1, IG, 30'hA0, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, NONE, '0, '0);
        #2 check("reset_drops_rvalid", 128'({if_rvalid, d_rvalid, mem_en, if_gnt, d_gnt}), '0);
        idle(NONE);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 30'hB0, 32'h1234, 1'b1, DGW, 30'hB0, 32'h1234);

        // Reset during HOLD_D: afterwards the arbiter is back in IDLE.
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 30'hC0, '0, 1'b0, EN, 30'hC0, '0);
        step(1'b0, 1'b1, 30'hD0, 1'b1, 1'b0, 30'hC0, '0, 1'b1, NONE, '0, '0);
        step(1'b1, 1'b1, 30'hD0, 1'b0, 1'b0, '0, '0, 1'b1, IG, 30'hD0, '0);
        idle(IRV);
        idle(NONE);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive data grants tolerated while fetch waits (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset; asserted (low) clears all state immediately.
REQ-004 SHALL have ports if_req input 1, if_addr input [31:2]: instruction-fetch read request and word address.
REQ-005 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output 32: fetch accept pulse, read-return strobe, read data.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_addr input [31:2], d_din input 32: execute-stage data request, write enable, word address, write data.
REQ-007 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output 32: data accept pulse, read-return strobe, read data.
REQ-008 SHALL have ports mem_addr output [31:2], mem_din output 32, mem_en output 1, mem_we output 1: shared single-port memory request.
REQ-009 SHALL have ports mem_ready input 1 (memory accepts request this cycle), mem_dout input 32 (read data, valid one cycle after an accepted read).

Function
REQ-010 SHALL keep FSM states IDLE, HOLD_I, HOLD_D; HOLD_x means requester x is presented to memory but not yet accepted.
REQ-011 In IDLE, winner SHALL be chosen combinationally in the same cycle: data over fetch, except fetch wins when starve count equals STARVE_LIMIT and if_req=1.
REQ-012 mem_en SHALL be 1 iff a winner exists; mem_addr/mem_we/mem_din SHALL carry the winner's fields (fetch: mem_we=0, mem_din=0); with mem_en=0 all SHALL be 0.
REQ-013 Request SHALL be accepted when mem_en=1 and mem_ready=1; the winner's gnt SHALL be high exactly in that cycle, other gnt low.
REQ-014 If winner presented with mem_ready=0, FSM SHALL enter HOLD_I/HOLD_D and keep that owner presented regardless of other requests until accepted, then return to IDLE.
REQ-015 Requesters SHALL hold req and fields stable until gnt; arbiter need not tolerate withdrawal in HOLD states (behaviour undefined).
REQ-016 An accepted read SHALL produce owner's rvalid=1 exactly one cycle later with rdata=mem_dout; accepted writes SHALL produce no rvalid.
REQ-017 if_rdata and d_rdata SHALL both equal mem_dout at all times; only rvalid distinguishes owner.
REQ-018 Back-to-back acceptance SHALL be supported: rvalid for request N and gnt for request N+1 may coincide; zero-bubble throughput when mem_ready=1.
REQ-019 Starve count (4 bits) SHALL increment on each data grant while if_req=1, saturate at STARVE_LIMIT, clear on fetch grant or any cycle with if_req=0.
REQ-020 With no requests, mem_en=0, FSM stays IDLE, no gnt/rvalid.

Reset
REQ-021 While rst=0: FSM=IDLE, starve count=0, read-pending flag=0; all gnt/rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-022 Reset asserted with a read outstanding or in HOLD SHALL discard it; no rvalid SHALL appear after rst returns high for pre-reset requests.
REQ-023 First arbitration SHALL occur in the first cycle with rst=1.

Configuration
REQ-024 Macro MEM_ARB_FAIRNESS_EN SHALL gate the starve counter: defined -> REQ-011/019 as written; undefined -> counter and STARVE_LIMIT logic absent, strict data-over-fetch priority.

Verification
REQ-025 if_req=1 addr 0x10 alone, mem_ready=1 -> if_gnt same cycle, mem_addr=0x10, next cycle if_rvalid=1, if_rdata=mem_dout.
REQ-026 if_req and d_req (we=1, din=0xDEADBEEF) together -> d_gnt first, mem_we=1, mem_din=0xDEADBEEF, no d_rvalid; if_gnt next cycle.
REQ-027 d_req read, mem_ready=0 for 3 cycles, if_req raised meanwhile -> HOLD_D, mem_addr stable, d_gnt on 4th cycle, d_rvalid one cycle later.
REQ-028 Fairness defined, STARVE_LIMIT=3, d_req and if_req held high -> grant sequence D,D,D,I repeating; macro undefined -> D forever.
REQ-029 rst pulsed low the cycle after an accepted read -> rvalid stays 0, outputs all 0 during and after reset until new request.
REQ-030 Alternating fetch/data reads, mem_ready=1 -> one gnt per cycle, each rvalid tagged to correct owner one cycle after its gnt.
